// File: rtl/score_uart_tx.sv
// Score/finish status transmitter: sends 'S' hi lo G|F '\n' frames
// over the txdata/txclk/txready byte interface whenever the game state changes.
module score_uart_tx #(
    parameter logic [7:0] START_CHAR    = 8'h53,
    parameter logic [7:0] END_CHAR      = 8'h0A,
    parameter int         STROBE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] score,
    input  logic       finish,
    input  logic       txready,
    output logic [7:0] txdata,
    output logic       txclk,
    output logic       busy,
    output logic [7:0] frames_sent
);

    typedef enum logic [1:0] {IDLE, WAITRDY, STROBE, SETTLE} state_t;

    localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    last_score;
    logic [7:0]    snap_score;
    logic          snap_fin;
    logic          fin_q;
    logic          fin_pend;
    logic          start;
    logic          last_byte;
    logic          strobe_done;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] frame_byte(
        input logic [2:0] i,
        input logic [7:0] s,
        input logic       f
    );
        case (i)
            3'd0:    return START_CHAR;
            3'd1:    return hex(s[7:4]);
            3'd2:    return hex(s[3:0]);
            3'd3:    return f ? 8'h46 : 8'h47;
            default: return END_CHAR;
        endcase
    endfunction

    assign start       = (state == IDLE) && enable &&
                         ((score != last_score) || fin_pend);
    assign last_byte   = (idx == 3'd4);
    assign strobe_done = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = WAITRDY;
            WAITRDY: if (txready) state_nx = STROBE;
            STROBE:  if (strobe_done) state_nx = SETTLE;
            SETTLE:  state_nx = last_byte ? IDLE : WAITRDY;
            default: state_nx = IDLE;
        endcase
    end

    // txclk is registered from the next state so the strobe is glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txclk       <= 1'b0;
            txdata      <= 8'h00;
            busy        <= 1'b0;
            frames_sent <= 8'h00;
            last_score  <= 8'h00;
            snap_score  <= 8'h00;
            snap_fin    <= 1'b0;
            fin_q       <= 1'b0;
            fin_pend    <= 1'b0;
            idx         <= 3'd0;
            cnt         <= '0;
        end else begin
            txclk <= (state_nx == STROBE);
            fin_q <= finish;
            cnt   <= (state == STROBE) ? cnt + 1'b1 : '0;
            if (start)                 fin_pend <= 1'b0;
            else if (finish && !fin_q) fin_pend <= 1'b1;
            if (start) begin
                snap_score <= score;
                snap_fin   <= finish;
                idx        <= 3'd0;
                busy       <= 1'b1;
                txdata     <= START_CHAR;
            end
            if (state == SETTLE) begin
                if (!last_byte) begin
                    idx    <= idx + 3'd1;
                    txdata <= frame_byte(idx + 3'd1, snap_score, snap_fin);
                end else begin
                    last_score  <= snap_score;
                    frames_sent <= frames_sent + 8'd1;
                    busy        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_uart_tx.sv
// Bench for score_uart_tx: vector table, corner sequences and a randomized
// run against a frame-level reference model.
module tb_score_uart_tx;

    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] score = 8'h00;
    logic       finish = 1'b0;
    logic       txready = 1'b1;
    logic [7:0] txdata;
    logic       txclk;
    logic       busy;
    logic [7:0] frames_sent;

    int n_cmp = 0;
    int n_bad = 0;
    logic rnd_rdy = 1'b0;
    logic [7:0] cap[$];
    logic prev = 1'b0;
    int hi_len = 0;
    logic [7:0] held = 8'h00;

    score_uart_tx #(
        .START_CHAR(8'h53),
        .END_CHAR(8'h0A),
        .STROBE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .score(score),
        .finish(finish),
        .txready(txready),
        .txdata(txdata),
        .txclk(txclk),
        .busy(busy),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  score;
        logic        fin;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [39:0] act,
                         input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hx(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    function automatic logic [39:0] enc(input logic [7:0] s, input logic f);
        return {8'h53, hx(int'(s) / 16), hx(int'(s) % 16),
                f ? 8'h46 : 8'h47, 8'h0A};
    endfunction

    // byte capture on each txclk rising edge, plus strobe-shape checks
    always @(negedge clk) begin
        if (!rst_n) begin
            prev = 1'b0;
            hi_len = 0;
        end else begin
            if (txclk) begin
                if (!prev) begin
                    cap.push_back(txdata);
                    held = txdata;
                    hi_len = 1;
                end else begin
                    hi_len++;
                    check("txdata_stable", 40'(txdata), 40'(held));
                end
            end else if (prev) begin
                check("strobe_width", 40'(hi_len), 40'(SC));
            end
            prev = txclk;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (rnd_rdy) txready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        cap.delete();
    endtask

    task automatic wait_frame(output logic [39:0] got);
        int a = 0;
        int b = 0;
        while (!busy && a < 60) begin tick(); a++; end
        while (busy && b < 1500) begin tick(); b++; end
        check("frame_timeout", 40'(a >= 60 || b >= 1500), 40'(0));
        check("nbytes", 40'(cap.size()), 40'(5));
        got = (cap.size() >= 5) ? {cap[0], cap[1], cap[2], cap[3], cap[4]}
                                : 40'h0;
        cap.delete();
    endtask

    task automatic quiet(input string name, input int cycles);
        int noisy = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (busy || txclk) noisy++;
        end
        check(name, 40'(noisy + cap.size()), 40'(0));
        cap.delete();
    endtask

    initial begin
        logic [39:0] got;
        int bad;
        int cnt;
        logic [7:0] m_last;
        logic m_prev;
        logic req;

        vecs[0] = '{8'h2A, 1'b0, {8'h53, 8'h32, 8'h41, 8'h47, 8'h0A}};
        vecs[1] = '{8'h2A, 1'b1, {8'h53, 8'h32, 8'h41, 8'h46, 8'h0A}};
        vecs[2] = '{8'h9F, 1'b1, {8'h53, 8'h39, 8'h46, 8'h46, 8'h0A}};
        vecs[3] = '{8'h00, 1'b0, {8'h53, 8'h30, 8'h30, 8'h47, 8'h0A}};
        vecs[4] = '{8'hA5, 1'b0, {8'h53, 8'h41, 8'h35, 8'h47, 8'h0A}};
        vecs[5] = '{8'hA5, 1'b1, {8'h53, 8'h41, 8'h35, 8'h46, 8'h0A}};

        tick();
        check("reset_outs", 40'({txdata, txclk, busy, frames_sent}), 40'(0));
        rst_n = 1'b1;
        tick();
        tick();
        check("post_reset_idle", 40'({txdata, txclk, busy, frames_sent}), 40'(0));

        for (int i = 0; i < 6; i++) begin
            score = vecs[i].score;
            finish = vecs[i].fin;
            wait_frame(got);
            check($sformatf("vec%0d_bytes", i), got, vecs[i].exp);
            check($sformatf("vec%0d_count", i), 40'(frames_sent), 40'(i + 1));
            quiet($sformatf("vec%0d_quiet", i), 15);
        end

        // txready stall in front of byte 2
        finish = 1'b0;
        score = 8'h00;
        do_reset();
        score = 8'h2A;
        for (int i = 0; i < 200 && cap.size() < 2; i++) tick();
        for (int i = 0; i < 20 && txclk; i++) tick();
        txready = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (txclk || txdata != 8'h41) bad++;
        end
        check("stall_hold", 40'(bad), 40'(0));
        txready = 1'b1;
        wait_frame(got);
        check("stall_frame", got, enc(8'h2A, 1'b0));

        // score changes during a frame are not seen until the next one
        score = 8'h5D;
        for (int i = 0; i < 60 && !busy; i++) tick();
        score = 8'hFF;
        tick();
        tick();
        tick();
        score = 8'h00;
        wait_frame(got);
        check("snap_first", got, enc(8'h5D, 1'b0));
        wait_frame(got);
        check("snap_second", got, enc(8'h00, 1'b0));
        quiet("snap_no_ff", 20);
        check("snap_count", 40'(frames_sent), 40'(3));

        // async reset in the middle of byte 3
        score = 8'h77;
        for (int i = 0; i < 200 && cap.size() < 4; i++) tick();
        check("pre_reset_strobe", 40'(txclk), 40'(1));
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", 40'({txdata, txclk, busy, frames_sent}), 40'(0));
        score = 8'h05;
        tick();
        tick();
        rst_n = 1'b1;
        cap.delete();
        wait_frame(got);
        check("after_reset_frame", got, enc(8'h05, 1'b0));
        check("after_reset_count", 40'(frames_sent), 40'(1));

        // 256 frames wrap the counter
        score = 8'h00;
        do_reset();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            score = i[0] ? 8'h3C : 8'hC3;
            wait_frame(got);
            if (got != enc(score, 1'b0)) bad++;
            if (i == 254) check("count_255", 40'(frames_sent), 40'(255));
        end
        check("wrap_frames", 40'(bad), 40'(0));
        check("count_wrap", 40'(frames_sent), 40'(0));

        enable = 1'b0;
        score = 8'h99;
        quiet("enable_off", 50);
        score = 8'h3C;
        enable = 1'b1;
        quiet("return_no_frame", 30);
        enable = 1'b0;
        finish = 1'b1;
        quiet("fin_pend_held", 20);
        enable = 1'b1;
        wait_frame(got);
        check("fin_pend_frame", got, enc(8'h3C, 1'b1));
        check("fin_pend_count", 40'(frames_sent), 40'(1));

        // randomized run against the frame-level model
        rnd_rdy = 1'b1;
        m_last = 8'h3C;
        m_prev = 1'b1;
        cnt = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) score = 8'($urandom_range(0, 255));
            finish = 1'($urandom_range(0, 1));
            req = (score != m_last) || (finish && !m_prev);
            if (req) begin
                wait_frame(got);
                check($sformatf("rnd%0d_frame", i), got, enc(score, finish));
                m_last = score;
                cnt++;
            end else begin
                quiet($sformatf("rnd%0d_quiet", i), 15);
            end
            m_prev = finish;
        end
        check("rnd_count", 40'(frames_sent), 40'(cnt % 256));
        rnd_rdy = 1'b0;
        txready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
